alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Shares one combinational 4-bit ALU (A,B,func -> 8-bit result) between two requesters.
//  Round-robin arbitration, valid/ready request handshake, registered valid/ack response.
//  Adds a multi-cycle multiply (func MUL_CODE) that the controller sequences as repeated ALU adds.
//  Sits between the switch/host request logic and the ALU; the ALU itself stays unregistered.
// PARAMETERS
//  MUL_CODE  3'b110  func code the controller executes as an iterated multiply (A*B)
//  ADD_CODE  3'b001  ALU func code driven during multiply iterations (8-bit A+B)
// PORTS
//  clock        in   1  system clock, all state on rising edge
//  reset_n      in   1  asynchronous active-low reset
//  req0_valid   in   1  requester 0 has an operation pending
//  req0_a       in   4  requester 0 operand A
//  req0_b       in   4  requester 0 operand B
//  req0_func    in   3  requester 0 function code
//  req0_ready   out  1  requester 0 operation accepted this cycle (when valid)
//  req1_valid   in   1  requester 1 has an operation pending
//  req1_a       in   4  requester 1 operand A
//  req1_b       in   4  requester 1 operand B
//  req1_func    in   3  requester 1 function code
//  req1_ready   out  1  requester 1 operation accepted this cycle (when valid)
//  alu_a        out  4  operand A to shared ALU
//  alu_b        out  4  operand B to shared ALU
//  alu_func     out  3  function code to shared ALU
//  alu_result   in   8  combinational ALU result
//  rsp_valid    out  1  response held for the requester named by rsp_id
//  rsp_id       out  1  0 = requester 0, 1 = requester 1
//  rsp_data     out  8  operation result
//  rsp_ack      in   1  consumer takes response this cycle
//  busy         out  1  1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, last_grant=1 (req0 wins first tie), all outputs 0,
//   op/acc/cnt regs 0. Reset mid-operation discards the operation; no response ever issues.
//  States IDLE, EXEC, MUL, RESP.
//  IDLE: grant = sole valid requester; both valid -> requester != last_grant. reqN_ready is
//   combinational = (state==IDLE) & grant==N; at most one ready high. On valid&ready capture
//   a/b/func/id, last_grant<=id; func==MUL_CODE -> MUL (acc<=0, cnt<=b), else -> EXEC.
//   Valid dropping before ready: legal, nothing captured. ready is 0 in every other state.
//  EXEC: alu_a/b/func = captured op; rsp_data<=alu_result; -> RESP. Any func incl. 110/111
//   not equal MUL_CODE is passed through unchanged.
//  MUL: cnt!=0: alu_a=acc[3:0], alu_b=op_a, alu_func=ADD_CODE; acc[3:0]<=alu_result[3:0],
//   acc[7:4]<=acc[7:4]+alu_result[4] (mod 16); cnt<=cnt-1. cnt==0: rsp_data<=acc; -> RESP.
//  alu_a/b/func = 0 in IDLE and RESP.
//  RESP: rsp_valid=1; rsp_data/rsp_id stable until rsp_ack; rsp_ack -> IDLE (rsp_valid=0 next).
//   rsp_ack outside RESP ignored.
//  Latency: accept at edge N -> rsp_valid high from N+2 (EXEC) or N+2+B (MUL, B=0 gives N+2).
//   Min issue interval 3 cycles with rsp_ack tied high.
// TESTING
//  Reset, both valid, func 001 A=3 B=5 each: req0_ready=1 first; rsp id0 data 8'h08 at N+2;
//   after ack req1 granted.
//  Both valid continuously, rsp_ack=1: grant sequence 0,1,0,1; no double grant, no starvation.
//  MUL A=15 B=15 -> rsp_data 8'hE1 at N+17, alu_func=001 during 15 MUL cycles; MUL A=9 B=0 -> 8'h00 at N+2.
//  func 010 A=A B=5 -> 8'hFF; func 101 A=A B=5 -> 8'hA5; func 111 -> 8'h00.
//  rsp_ack low 5 cycles in RESP: rsp_valid/data/id stable, both ready 0, busy 1.
//  reset_n low mid-MUL: outputs 0 immediately; after release no rsp_valid, req0 wins next tie.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Two-requester front end for one shared combinational ALU: round-robin grant,
// captured operation, iterated-add multiply and a held response until acknowledged.
module alu_share_ctrl #(
   parameter logic [2:0] MUL_CODE = 3'b110,
   parameter logic [2:0] ADD_CODE = 3'b001
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       req0_valid,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic [2:0] req0_func,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   input  logic [2:0] req1_func,
   output logic       req1_ready,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_func,
   input  logic [7:0] alu_result,
   output logic       rsp_valid,
   output logic       rsp_id,
   output logic [7:0] rsp_data,
   input  logic       rsp_ack,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      MUL  = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic [3:0] op_a_q, op_a_d;
   logic [3:0] op_b_q, op_b_d;
   logic [2:0] op_func_q, op_func_d;
   logic       op_id_q, op_id_d;
   logic [7:0] acc_q, acc_d;
   logic [3:0] cnt_q, cnt_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_id_q, rsp_id_d;
   logic [7:0] rsp_data_q, rsp_data_d;

   logic       grant_vld_s;
   logic       grant_id_s;
   logic [3:0] sel_a_s;
   logic [3:0] sel_b_s;
   logic [2:0] sel_func_s;

   // Round-robin arbiter: on a tie the requester that did not win last time is picked.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_vld_s = 1'b1;
         grant_id_s  = ~last_grant_q;
      end else if (req0_valid) begin
         grant_vld_s = 1'b1;
         grant_id_s  = 1'b0;
      end else if (req1_valid) begin
         grant_vld_s = 1'b1;
         grant_id_s  = 1'b1;
      end else begin
         grant_vld_s = 1'b0;
         grant_id_s  = 1'b0;
      end
   end

   assign sel_a_s    = grant_id_s ? req1_a    : req0_a;
   assign sel_b_s    = grant_id_s ? req1_b    : req0_b;
   assign sel_func_s = grant_id_s ? req1_func : req0_func;

   assign req0_ready = (state_q == IDLE) && grant_vld_s && !grant_id_s;
   assign req1_ready = (state_q == IDLE) && grant_vld_s &&  grant_id_s;

   // ALU operand steering; kept apart from next-state logic so no loop through alu_result.
   always_comb begin
      alu_a    = 4'd0;
      alu_b    = 4'd0;
      alu_func = 3'd0;
      case (state_q)
         EXEC: begin
            alu_a    = op_a_q;
            alu_b    = op_b_q;
            alu_func = op_func_q;
         end
         MUL: begin
            if (cnt_q != 4'd0) begin
               alu_a    = acc_q[3:0];
               alu_b    = op_a_q;
               alu_func = ADD_CODE;
            end else begin
               alu_a    = 4'd0;
               alu_b    = 4'd0;
               alu_func = 3'd0;
            end
         end
         default: begin
            alu_a    = 4'd0;
            alu_b    = 4'd0;
            alu_func = 3'd0;
         end
      endcase
   end

   // Controller next state: capture, execute, multiply iterations, response hold.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_func_d    = op_func_q;
      op_id_d      = op_id_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (grant_vld_s) begin
               op_a_d       = sel_a_s;
               op_b_d       = sel_b_s;
               op_func_d    = sel_func_s;
               op_id_d      = grant_id_s;
               last_grant_d = grant_id_s;
               if (sel_func_s == MUL_CODE) begin
                  acc_d   = 8'd0;
                  cnt_d   = sel_b_s;
                  state_d = MUL;
               end else begin
                  state_d = EXEC;
               end
            end else begin
               state_d = IDLE;
            end
         end
         EXEC: begin
            rsp_data_d  = alu_result;
            rsp_id_d    = op_id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         MUL: begin
            // Low nibble comes back from the ALU; its carry ripples into the high nibble here.
            if (cnt_q != 4'd0) begin
               acc_d = {acc_q[7:4] + {3'd0, alu_result[4]}, alu_result[3:0]};
               cnt_d = cnt_q - 4'd1;
            end else begin
               rsp_data_d  = acc_q;
               rsp_id_d    = op_id_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ack) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         op_a_q       <= 4'd0;
         op_b_q       <= 4'd0;
         op_func_q    <= 3'd0;
         op_id_q      <= 1'b0;
         acc_q        <= 8'd0;
         cnt_q        <= 4'd0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_func_q    <= op_func_d;
         op_id_q      <= op_id_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: accepts push expected responses, a monitor
// pops and checks them (id, data, arrival cycle) and also checks arbitration rules.
module tb_alu_share_ctrl;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       req0_valid, req1_valid;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0] req0_func, req1_func;
   logic       req0_ready, req1_ready;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_func;
   logic [7:0] alu_result;
   logic       rsp_valid, rsp_id, rsp_ack, busy;
   logic [7:0] rsp_data;

   typedef struct {
      logic       id;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   exp_t       cur;
   logic       seen = 1'b0;
   int         gl[$];
   int         acyc[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         acc_cnt0 = 0;
   int         acc_cnt1 = 0;
   int         rsp_cnt = 0;
   int         add_cycles = 0;
   logic [2:0] last_exec_func = 3'd0;
   logic [7:0] exp_d0, exp_d1;
   int         exp_x0, exp_x1;

   alu_share_ctrl dut (
      .clock(clock), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
      .req1_ready(req1_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
      .busy(busy)
   );

   // Reference ALU sitting on the shared port.
   always_comb begin
      case (alu_func)
         3'b000:  alu_result = {4'd0, alu_a} - {4'd0, alu_b};
         3'b001:  alu_result = {4'd0, alu_a} + {4'd0, alu_b};
         3'b010:  alu_result = ~{4'd0, alu_a & alu_b};
         3'b011:  alu_result = {4'd0, alu_a ^ alu_b};
         3'b100:  alu_result = {4'd0, alu_a | alu_b};
         3'b101:  alu_result = {alu_a, alu_b};
         default: alu_result = 8'd0;
      endcase
   end

   initial forever #5 clock = ~clock;

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Monitor: records accepts, checks responses against the scoreboard.
   initial forever begin
      @(negedge clock or negedge reset_n);
      if (!reset_n) begin
         sb.delete();
         seen = 1'b0;
      end else begin
         if (req0_valid && req1_valid) chk("double_grant", int'(req0_ready & req1_ready), 0);
         if (busy && (req0_valid || req1_valid))
            chk("ready_while_busy", int'(req0_ready | req1_ready), 0);
         if (busy && !rsp_valid && alu_func == 3'b001) add_cycles++;
         if (busy && !rsp_valid) last_exec_func = alu_func;
         if (req0_valid && req0_ready) begin
            sb.push_back('{1'b0, exp_d0, cyc + 2 + exp_x0});
            gl.push_back(0);
            acyc.push_back(cyc);
            acc_cnt0++;
         end
         if (req1_valid && req1_ready) begin
            sb.push_back('{1'b1, exp_d1, cyc + 2 + exp_x1});
            gl.push_back(1);
            acyc.push_back(cyc);
            acc_cnt1++;
         end
         if (rsp_valid) begin
            if (!seen) begin
               rsp_cnt++;
               if (sb.size() == 0) begin
                  chk("unexpected_rsp", 1, 0);
               end else begin
                  cur  = sb.pop_front();
                  seen = 1'b1;
                  chk("rsp_cycle", cyc, cur.cyc);
               end
            end
            if (seen) begin
               chk("rsp_id", int'(rsp_id), int'(cur.id));
               chk("rsp_data", int'(rsp_data), int'(cur.data));
               chk("busy_in_resp", int'(busy), 1);
            end
            if (rsp_ack) seen = 1'b0;
         end
      end
   end

   task automatic set_op(input int n, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] f, input logic [7:0] d, input int x);
      if (n == 0) begin
         req0_a = a; req0_b = b; req0_func = f; exp_d0 = d; exp_x0 = x;
      end else begin
         req1_a = a; req1_b = b; req1_func = f; exp_d1 = d; exp_x1 = x;
      end
   endtask

   // Hold valids until each requester has had k accepts, then wait for the response to drain.
   task automatic run_ops(input int k0, input int k1);
      int t0, t1, b;
      t0 = acc_cnt0 + k0;
      t1 = acc_cnt1 + k1;
      if (k0 > 0) req0_valid = 1'b1;
      if (k1 > 0) req1_valid = 1'b1;
      b = 0;
      while (b < 300) begin
         @(posedge clock); #1;
         if (acc_cnt0 >= t0) req0_valid = 1'b0;
         if (acc_cnt1 >= t1) req1_valid = 1'b0;
         if (!req0_valid && !req1_valid && sb.size() == 0 && !busy && !rsp_valid) break;
         b++;
      end
      chk("run_ops_timeout", int'(b < 300), 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic wait_accept(input int n, input int start);
      int b;
      b = 0;
      while (((n == 0) ? acc_cnt0 : acc_cnt1) == start && b < 50) begin
         @(posedge clock); #1;
         b++;
      end
      chk("accept_timeout", int'(b < 50), 1);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
      chk({tag, "_rsp_id"}, int'(rsp_id), 0);
      chk({tag, "_rsp_data"}, int'(rsp_data), 0);
      chk({tag, "_alu_a"}, int'(alu_a), 0);
      chk({tag, "_alu_b"}, int'(alu_b), 0);
      chk({tag, "_alu_func"}, int'(alu_func), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_ready0"}, int'(req0_ready), 0);
      chk({tag, "_ready1"}, int'(req1_ready), 0);
   endtask

   function automatic int gl_at(input int i);
      return (i < gl.size()) ? gl[i] : -1;
   endfunction

   function automatic int gap_at(input int i);
      return (i + 1 < acyc.size()) ? acyc[i+1] - acyc[i] : -1;
   endfunction

   initial begin
      int base, pre, b;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ack = 1'b0;
      set_op(0, 4'd0, 4'd0, 3'd0, 8'd0, 0);
      set_op(1, 4'd0, 4'd0, 3'd0, 8'd0, 0);
      repeat (3) @(posedge clock);
      #2;
      check_quiet("reset");
      reset_n = 1'b1;
      @(posedge clock); #1;
      check_quiet("post_reset");
      rsp_ack = 1'b1;

      // Tie after reset: req0 first, then req1 one issue interval later.
      set_op(0, 4'd3, 4'd5, 3'b001, 8'h08, 0);
      set_op(1, 4'd3, 4'd5, 3'b001, 8'h08, 0);
      base = gl.size();
      run_ops(1, 1);
      chk("t1_first_grant", gl_at(base), 0);
      chk("t1_second_grant", gl_at(base + 1), 1);
      chk("t1_gap", gap_at(base), 3);

      // Continuous contention alternates 0,1,0,1 at the minimum interval.
      set_op(0, 4'd1, 4'd2, 3'b001, 8'h03, 0);
      set_op(1, 4'd4, 4'd4, 3'b001, 8'h08, 0);
      base = gl.size();
      run_ops(2, 2);
      for (int i = 0; i < 4; i++) chk("t2_grant_seq", gl_at(base + i), i % 2);
      for (int i = 0; i < 3; i++) chk("t2_gap", gap_at(base + i), 3);

      // Iterated multiply.
      add_cycles = 0;
      set_op(0, 4'd15, 4'd15, 3'b110, 8'hE1, 15);
      run_ops(1, 0);
      chk("mul15_add_cycles", add_cycles, 15);
      add_cycles = 0;
      set_op(0, 4'd9, 4'd0, 3'b110, 8'h00, 0);
      run_ops(1, 0);
      chk("mul_b0_add_cycles", add_cycles, 0);
      set_op(1, 4'd3, 4'd4, 3'b110, 8'h0C, 4);
      run_ops(0, 1);

      // Pass-through function codes.
      set_op(1, 4'hA, 4'd5, 3'b010, 8'hFF, 0);
      run_ops(0, 1);
      set_op(1, 4'hA, 4'd5, 3'b101, 8'hA5, 0);
      run_ops(0, 1);
      set_op(1, 4'd3, 4'd4, 3'b111, 8'h00, 0);
      run_ops(0, 1);
      chk("func111_passthru", int'(last_exec_func), 7);

      // Held response with ack low; req0 waits meanwhile.
      rsp_ack = 1'b0;
      set_op(1, 4'd2, 4'd2, 3'b001, 8'h04, 0);
      set_op(0, 4'd1, 4'd1, 3'b001, 8'h02, 0);
      pre = acc_cnt1;
      req1_valid = 1'b1;
      wait_accept(1, pre);
      req1_valid = 1'b0;
      req0_valid = 1'b1;
      b = 0;
      while (!rsp_valid && b < 20) begin
         @(posedge clock); #1;
         b++;
      end
      chk("stall_rsp_timeout", int'(b < 20), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock); #1;
         chk("stall_rsp_valid", int'(rsp_valid), 1);
         chk("stall_rsp_data", int'(rsp_data), 8'h04);
         chk("stall_rsp_id", int'(rsp_id), 1);
         chk("stall_ready0", int'(req0_ready), 0);
         chk("stall_ready1", int'(req1_ready), 0);
         chk("stall_busy", int'(busy), 1);
      end
      @(posedge clock); #1;
      rsp_ack = 1'b1;
      run_ops(1, 0);

      // Reset in the middle of a multiply.
      set_op(0, 4'd15, 4'd15, 3'b110, 8'hE1, 15);
      pre = acc_cnt0;
      req0_valid = 1'b1;
      wait_accept(0, pre);
      req0_valid = 1'b0;
      repeat (5) @(posedge clock);
      #2;
      chk("mid_mul_busy", int'(busy), 1);
      pre = rsp_cnt;
      reset_n = 1'b0;
      #1;
      check_quiet("mid_mul_reset");
      @(negedge clock); #2;
      reset_n = 1'b1;
      repeat (25) @(posedge clock);
      #1;
      chk("no_rsp_after_reset", rsp_cnt, pre);
      set_op(0, 4'd1, 4'd1, 3'b001, 8'h02, 0);
      set_op(1, 4'd2, 4'd3, 3'b001, 8'h05, 0);
      base = gl.size();
      run_ops(1, 1);
      chk("post_reset_first_grant", gl_at(base), 0);
      chk("post_reset_second_grant", gl_at(base + 1), 1);

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
